// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet core: action codes, button indices and the
// care-action controller state encoding.
`timescale 1ns/1ps
package tamagotchi_pkg;

  localparam int NUM_BUTTONS = 6;

  typedef enum logic [2:0] {
    ACT_NONE   = 3'd0,
    ACT_FEED   = 3'd1,
    ACT_PLAY   = 3'd2,
    ACT_HEAL   = 3'd3,
    ACT_CLEAN  = 3'd4,
    ACT_SLEEP  = 3'd5,
    ACT_SOCIAL = 3'd6
  } action_e;

  typedef enum logic [2:0] {
    BTN_FEED   = 3'd0,
    BTN_PLAY   = 3'd1,
    BTN_HEAL   = 3'd2,
    BTN_CLEAN  = 3'd3,
    BTN_SLEEP  = 3'd4,
    BTN_SOCIAL = 3'd5
  } btn_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OFFER    = 2'd1,
    ST_COOLDOWN = 2'd2
  } ctrl_state_e;

  function automatic logic [3:0] popcount6(input logic [NUM_BUTTONS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: two-flop synchroniser followed by a stability counter that only
// lets the accepted level follow the input after it has differed long enough.
`timescale 1ns/1ps
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level
);

  localparam int CNT_W = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(int'(DEBOUNCE_CYCLES) - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      // synchroniser stages
      sync_p0 <= button;
      sync_p1 <= sync_p0;
      // any agreement restarts the stability window
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/care_action_ctrl.sv
// Care-button front end: debounced rising edges are pended per button, the
// lowest index wins, is offered over valid/ready, then a tick-based cooldown runs.
`timescale 1ns/1ps
module care_action_ctrl
  import tamagotchi_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
  parameter logic [7:0]  COOLDOWN_TICKS  = 8'd4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic                   tick,
  input  logic                   action_ready,
  output logic                   action_valid,
  output logic [2:0]             action_code,
  output logic                   cooldown_active,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [7:0]             dropped_cnt
);

  ctrl_state_e            state;
  logic [7:0]             cool_cnt;
  logic [NUM_BUTTONS-1:0] btn_level_q;
  logic [NUM_BUTTONS-1:0] pending;
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] grant;
  logic [NUM_BUTTONS-1:0] dropped;
  logic [NUM_BUTTONS-1:0] accepted;
  logic [2:0]             grant_idx;

  function automatic logic [2:0] lowest_index(input logic [NUM_BUTTONS-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {5'b00000, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : gen_db
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .button(buttons[g]),
      .level (btn_level[g])
    );
  end

  always_comb begin
    rise      = btn_level & ~btn_level_q;
    grant_idx = lowest_index(pending);
    grant     = '0;
    if (state == ST_IDLE && pending != '0) begin
      grant[grant_idx] = 1'b1;
    end
    // cooldown discards every press; otherwise only repeats of a still-pending button
    if (state == ST_COOLDOWN) begin
      dropped = rise;
    end else begin
      dropped = rise & pending & ~grant;
    end
    accepted = rise & ~dropped;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      cool_cnt        <= 8'd0;
      btn_level_q     <= '0;
      pending         <= '0;
      dropped_cnt     <= 8'd0;
      action_valid    <= 1'b0;
      action_code     <= ACT_NONE;
      cooldown_active <= 1'b0;
    end else begin
      btn_level_q <= btn_level;
      pending     <= (pending & ~grant) | accepted;
      dropped_cnt <= sat_add8(dropped_cnt, popcount6(dropped));
      case (state)
        ST_IDLE: begin
          if (pending != '0) begin
            action_valid <= 1'b1;
            action_code  <= grant_idx + 3'd1;
            state        <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (action_ready) begin
            action_valid <= 1'b0;
            action_code  <= ACT_NONE;
            if (COOLDOWN_TICKS == 8'd0) begin
              state <= ST_IDLE;
            end else begin
              state           <= ST_COOLDOWN;
              cool_cnt        <= COOLDOWN_TICKS;
              cooldown_active <= 1'b1;
            end
          end
        end
        ST_COOLDOWN: begin
          if (tick) begin
            if (cool_cnt <= 8'd1) begin
              state           <= ST_IDLE;
              cool_cnt        <= 8'd0;
              cooldown_active <= 1'b0;
            end else begin
              cool_cnt <= cool_cnt - 8'd1;
            end
          end
        end
        default: begin
          state           <= ST_IDLE;
          action_valid    <= 1'b0;
          action_code     <= ACT_NONE;
          cooldown_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_care_action_ctrl.sv
// Bench for care_action_ctrl: two instances (cooldown 3 ticks and no cooldown)
// share stimulus and are checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_care_action_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] buttons = '0;
  logic       tick = 1'b0;
  logic       action_ready = 1'b0;

  logic       av [2];
  logic [2:0] ac [2];
  logic       cl [2];
  logic [5:0] lv [2];
  logic [7:0] dc [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  care_action_ctrl #(.DEBOUNCE_CYCLES(16'd4), .COOLDOWN_TICKS(8'd3)) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .tick(tick), .action_ready(action_ready),
    .action_valid(av[0]), .action_code(ac[0]), .cooldown_active(cl[0]),
    .btn_level(lv[0]), .dropped_cnt(dc[0]));

  care_action_ctrl #(.DEBOUNCE_CYCLES(16'd4), .COOLDOWN_TICKS(8'd0)) dut0 (
    .clk(clk), .reset(reset), .buttons(buttons), .tick(tick), .action_ready(action_ready),
    .action_valid(av[1]), .action_code(ac[1]), .cooldown_active(cl[1]),
    .btn_level(lv[1]), .dropped_cnt(dc[1]));

  // Model state: raw history, accepted levels, pended presses, offer and cooldown left.
  logic [5:0] m_raw1 [2];
  logic [5:0] m_raw2 [2];
  logic [5:0] m_lvl  [2];
  logic [5:0] m_lvlq [2];
  logic [5:0] m_pend [2];
  int         m_run  [2][6];
  bit         m_valid[2];
  int         m_code [2];
  int         m_cool [2];
  int         m_drop [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input int ct);
    logic [5:0] rise, grant, drop, acc;
    bit in_cool;
    if (reset) begin
      m_raw1[i] = '0; m_raw2[i] = '0; m_lvl[i] = '0; m_lvlq[i] = '0; m_pend[i] = '0;
      for (int b = 0; b < 6; b++) m_run[i][b] = 0;
      m_valid[i] = 0; m_code[i] = 0; m_cool[i] = 0; m_drop[i] = 0;
      return;
    end
    rise    = m_lvl[i] & ~m_lvlq[i];
    in_cool = (m_cool[i] > 0);
    grant   = '0;
    if (!m_valid[i] && !in_cool && m_pend[i] != '0) begin
      for (int b = 5; b >= 0; b--) if (m_pend[i][b]) grant = 6'(1 << b);
    end
    drop = in_cool ? rise : (rise & m_pend[i] & ~grant);
    acc  = rise & ~drop;
    m_drop[i] = m_drop[i] + $countones(drop);
    if (m_drop[i] > 255) m_drop[i] = 255;
    m_pend[i] = (m_pend[i] & ~grant) | acc;
    if (m_valid[i] && action_ready) begin
      m_valid[i] = 0; m_code[i] = 0; m_cool[i] = ct;
    end else if (in_cool && tick) begin
      m_cool[i] = m_cool[i] - 1;
    end
    for (int b = 0; b < 6; b++) if (grant[b]) begin m_valid[i] = 1; m_code[i] = b + 1; end
    m_lvlq[i] = m_lvl[i];
    for (int b = 0; b < 6; b++) begin
      if (m_raw2[i][b] != m_lvl[i][b]) begin
        m_run[i][b]++;
        if (m_run[i][b] == D) begin
          m_lvl[i][b] = m_raw2[i][b];
          m_run[i][b] = 0;
        end
      end else begin
        m_run[i][b] = 0;
      end
    end
    m_raw2[i] = m_raw1[i];
    m_raw1[i] = buttons;
  endtask

  // The single per-cycle compare point: advance the model over the edge, then check both DUTs.
  task automatic step();
    @(posedge clk);
    model_step(0, 3);
    model_step(1, 0);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid%0d", i), 32'(av[i]), 32'(m_valid[i]));
      chk($sformatf("code%0d", i), 32'(ac[i]), 32'(m_code[i]));
      chk($sformatf("cooldown%0d", i), 32'(cl[i]), 32'(m_cool[i] > 0));
      chk($sformatf("level%0d", i), 32'(lv[i]), 32'(m_lvl[i]));
      chk($sformatf("dropped%0d", i), 32'(dc[i]), 32'(m_drop[i]));
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_offer(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 30 && !ok; k++) begin
      step();
      if (av[0] === 1'b1) ok = 1;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; buttons = '0; tick = 1'b0; action_ready = 1'b0;
    steps(2);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset_valid", 32'(av[0]), 32'd0);
    chk("reset_code", 32'(ac[0]), 32'd0);
    chk("reset_level", 32'(lv[0]), 32'd0);
    chk("reset_dropped", 32'(dc[0]), 32'd0);

    // feed press: level after 6 edges, offer 2 edges later, held until ready
    buttons = 6'b000001;
    steps(5);
    chk("t1_level_early", 32'(lv[0]), 32'd0);
    step();
    chk("t1_level", 32'(lv[0]), 32'd1);
    step();
    chk("t1_not_yet", 32'(av[0]), 32'd0);
    step();
    chk("t1_valid", 32'(av[0]), 32'd1);
    chk("t1_code", 32'(ac[0]), 32'd1);
    for (int k = 0; k < 10; k++) begin tick = k[0]; step(); end
    tick = 1'b0;
    chk("t1_held", 32'(ac[0]), 32'd1);
    action_ready = 1'b1; step(); action_ready = 1'b0;
    chk("t1_accepted", 32'(av[0]), 32'd0);
    chk("t1_cooldown", 32'(cl[0]), 32'd1);
    buttons = '0;
    run_ticks(3);
    chk("t1_cool_done", 32'(cl[0]), 32'd0);
    steps(8);

    // glitch shorter than the debounce window
    buttons = 6'b000100; steps(3);
    buttons = '0; steps(10);
    chk("t2_level", 32'(lv[0]), 32'd0);
    chk("t2_valid", 32'(av[0]), 32'd0);
    chk("t2_dropped", 32'(dc[0]), 32'd0);

    // simultaneous play + sleep: priority then cooldown then second offer
    buttons = 6'b010010;
    wait_offer("t3_offer");
    chk("t3_code_first", 32'(ac[0]), 32'd2);
    action_ready = 1'b1; step(); action_ready = 1'b0;
    buttons = '0;
    run_ticks(3);
    chk("t3_valid_second", 32'(av[0]), 32'd1);
    chk("t3_code_second", 32'(ac[0]), 32'd5);
    action_ready = 1'b1; step(); action_ready = 1'b0;
    run_ticks(3);
    steps(4);

    // two clean presses during cooldown are discarded
    buttons = 6'b000001;
    wait_offer("t4_offer");
    action_ready = 1'b1; step(); action_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      buttons = 6'b001000; steps(8);
      buttons = 6'b000000; steps(8);
    end
    chk("t4_dropped", 32'(dc[0]), 32'd2);
    run_ticks(3);
    steps(10);
    chk("t4_idle_valid", 32'(av[0]), 32'd0);
    chk("t4_idle_cool", 32'(cl[0]), 32'd0);

    // long stall in OFFER with ticks
    buttons = 6'b100000;
    wait_offer("t5_offer");
    for (int k = 0; k < 100; k++) begin
      tick = (k % 4 == 0);
      step();
      chk("t5_stable_valid", 32'(av[0]), 32'd1);
      chk("t5_stable_code", 32'(ac[0]), 32'd6);
    end
    tick = 1'b0;
    action_ready = 1'b1; step(); action_ready = 1'b0;
    buttons = '0;
    run_ticks(3);

    // zero-cooldown instance: back-to-back offers one idle cycle apart
    do_reset();
    buttons = 6'b000011; action_ready = 1'b1;
    steps(8);
    chk("t5b_valid_a", 32'(av[1]), 32'd1);
    chk("t5b_code_a", 32'(ac[1]), 32'd1);
    step();
    chk("t5b_gap", 32'(av[1]), 32'd0);
    step();
    chk("t5b_valid_b", 32'(av[1]), 32'd1);
    chk("t5b_code_b", 32'(ac[1]), 32'd2);
    step();
    action_ready = 1'b0;

    // reset in the middle of an offer with social pended
    do_reset();
    buttons = 6'b000001;
    wait_offer("t6_offer");
    buttons = 6'b100001; steps(8);
    reset = 1'b1; buttons = '0; step();
    chk("t6_valid", 32'(av[0]), 32'd0);
    chk("t6_code", 32'(ac[0]), 32'd0);
    chk("t6_cool", 32'(cl[0]), 32'd0);
    chk("t6_level", 32'(lv[0]), 32'd0);
    chk("t6_dropped", 32'(dc[0]), 32'd0);
    step(); reset = 1'b0;
    steps(20);
    chk("t6_no_offer", 32'(av[0]), 32'd0);

    // saturate the drop counter during cooldown
    buttons = 6'b000001;
    wait_offer("t6b_offer");
    action_ready = 1'b1; step(); action_ready = 1'b0;
    for (int r = 0; r < 50; r++) begin
      buttons = 6'h3F; steps(7);
      buttons = 6'h00; steps(7);
    end
    chk("t6b_saturated", 32'(dc[0]), 32'd255);

    // randomised traffic
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      for (int b = 0; b < 6; b++) if ($urandom_range(0, 11) == 0) buttons[b] = ~buttons[b];
      tick         = ($urandom_range(0, 5) == 0);
      action_ready = ($urandom_range(0, 2) == 0);
      reset        = ($urandom_range(0, 799) == 0);
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
